// File: rtl/dot_feeder_17.sv
// ============================================================================
// Module   : dot_feeder_17
// Purpose  : Upstream sequencer for one dot_channel_17. Accepts 36-element
//            input vectors, walks every (cs, phase) weight slice of a frame
//            in cs-major / phase-minor order, drives the channel load strobes,
//            captures each dot-product result and hands it out, tagged with
//            its cs/phase, through a one-entry valid/ready output register.
// Options  : DOT_FEEDER_TIMEOUT_EN - when defined, RUN is bounded by TIMEOUT
//            cycles; expiry raises a sticky err and skips the slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Element width normally comes from num_data.v; fall back to 16 bits.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_feeder_17 #(
  parameter int NUM_CS    = 16,
  parameter int NUM_PHASE = 8
`ifdef DOT_FEEDER_TIMEOUT_EN
  ,
  // Only meaningful when the timeout counter exists.
  parameter int TIMEOUT   = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [36*`DATA_LEN-1:0] s_data,
  output logic                    dc_load,
  output logic                    ws_load,
  output logic [3:0]              cs,
  output logic [2:0]              phase,
  output logic [36*`DATA_LEN-1:0] d,
  input  logic                    dc_valid,
  input  logic [`DATA_LEN-1:0]    dc_q,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [`DATA_LEN-1:0]    m_data,
  output logic [3:0]              m_cs,
  output logic [2:0]              m_phase,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err
);

  localparam int DW = `DATA_LEN;
  localparam int VW = 36 * DW;

  // Coordinates of the final slice of a frame.
  localparam logic [3:0] LAST_CS = 4'(NUM_CS - 1);
  localparam logic [2:0] LAST_PH = 3'(NUM_PHASE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IN = 2'd1,
    S_RUN     = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cs_q, cs_d;
  logic [2:0]      phase_q, phase_d;
  logic [VW-1:0]   d_q, d_d;
  logic            dc_load_q, dc_load_d;
  logic            ws_load_q, ws_load_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [3:0]      m_cs_q, m_cs_d;
  logic [2:0]      m_phase_q, m_phase_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic            timeout_hit;
  logic            last_slice;

`ifdef DOT_FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  // RUN has lasted TIMEOUT cycles when the count reaches TIMEOUT-1.
  assign timeout_hit = (run_cnt_q == CNT_W'(TIMEOUT - 1));

  // Count RUN cycles; cleared while waiting for the next input vector.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q == S_WAIT_IN) begin
      run_cnt_d = '0;
    end else if ((state_q == S_RUN) && !dc_valid && !timeout_hit) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  // RUN cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end
`else
  // Without the counter RUN waits for the channel indefinitely.
  assign timeout_hit = 1'b0;
`endif

  assign last_slice = (cs_q == LAST_CS) && (phase_q == LAST_PH);

  // Next-state, slice sequencing, output-slot and input-handshake logic.
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    phase_d      = phase_q;
    d_d          = d_q;
    dc_load_d    = dc_load_q;
    ws_load_d    = ws_load_q;
    m_data_d     = m_data_q;
    m_cs_d       = m_cs_q;
    m_phase_d    = m_phase_q;
    busy_d       = busy_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    s_ready      = 1'b0;
    // A consumed result frees the slot; a capture below may refill it.
    m_valid_d    = m_valid_q && !m_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_IN;
          cs_d    = '0;
          phase_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_WAIT_IN: begin
        // Only take a vector if its result will have somewhere to go.
        s_ready = !m_valid_q || m_ready;
        if (s_valid && s_ready) begin
          d_d       = s_data;
          dc_load_d = 1'b1;
          ws_load_d = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (dc_valid) begin
          // Slot is known free: acceptance required it and nothing else fills it.
          m_data_d  = dc_q;
          m_cs_d    = cs_q;
          m_phase_d = phase_q;
          m_valid_d = 1'b1;
          dc_load_d = 1'b0;
          ws_load_d = 1'b0;
          state_d   = S_GAP;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          dc_load_d = 1'b0;
          ws_load_d = 1'b0;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        // One cycle with loads low lets the channel clear its inner count.
        if (phase_q == LAST_PH) begin
          phase_d = '0;
          cs_d    = cs_q + 4'd1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
        if (last_slice) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WAIT_IN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cs_q         <= '0;
      phase_q      <= '0;
      d_q          <= '0;
      dc_load_q    <= 1'b0;
      ws_load_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_cs_q       <= '0;
      m_phase_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      phase_q      <= phase_d;
      d_q          <= d_d;
      dc_load_q    <= dc_load_d;
      ws_load_q    <= ws_load_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_cs_q       <= m_cs_d;
      m_phase_q    <= m_phase_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign cs         = cs_q;
  assign phase      = phase_q;
  assign d          = d_q;
  assign dc_load    = dc_load_q;
  assign ws_load    = ws_load_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_cs       = m_cs_q;
  assign m_phase    = m_phase_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_feeder_17.sv
// ============================================================================
// Module   : tb_dot_feeder_17
// Purpose  : Directed self-checking bench for dot_feeder_17. Instance a uses
//            the default 16x8 frame, instance b a single-slice 1x1 frame.
//            A small dot_channel model per instance raises valid on the 7th
//            load-high edge after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_dot_feeder_17;

  localparam int DW = `DATA_LEN;
  localparam int VW = 36 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic s_data_ok;
  logic [VW-1:0] s_data;

  // instance a (16 x 8)
  logic          a_start = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b1;
  logic          a_s_ready, a_dc_load, a_ws_load, a_dc_valid, a_m_valid;
  logic          a_busy, a_frame_done, a_err;
  logic [3:0]    a_cs, a_m_cs;
  logic [2:0]    a_phase, a_m_phase;
  logic [VW-1:0] a_d;
  logic [DW-1:0] a_dc_q, a_m_data;

  // instance b (1 x 1)
  logic          b_start = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b1;
  logic          b_s_ready, b_dc_load, b_ws_load, b_dc_valid, b_m_valid;
  logic          b_busy, b_frame_done, b_err;
  logic [3:0]    b_cs, b_m_cs;
  logic [2:0]    b_phase, b_m_phase;
  logic [VW-1:0] b_d;
  logic [DW-1:0] b_dc_q, b_m_data;

  dot_feeder_17 u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .s_valid(a_s_valid),
    .s_ready(a_s_ready), .s_data(s_data), .dc_load(a_dc_load),
    .ws_load(a_ws_load), .cs(a_cs), .phase(a_phase), .d(a_d),
    .dc_valid(a_dc_valid), .dc_q(a_dc_q), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .m_data(a_m_data), .m_cs(a_m_cs),
    .m_phase(a_m_phase), .busy(a_busy), .frame_done(a_frame_done),
    .err(a_err)
  );

  dot_feeder_17 #(.NUM_CS(1), .NUM_PHASE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .s_data(s_data), .dc_load(b_dc_load),
    .ws_load(b_ws_load), .cs(b_cs), .phase(b_phase), .d(b_d),
    .dc_valid(b_dc_valid), .dc_q(b_dc_q), .m_valid(b_m_valid),
    .m_ready(b_m_ready), .m_data(b_m_data), .m_cs(b_m_cs),
    .m_phase(b_m_phase), .busy(b_busy), .frame_done(b_frame_done),
    .err(b_err)
  );

  // Channel model a: result word encodes the slice it was computed for.
  int   a_cnt;
  logic a_ch_en = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt      <= 0;
      a_dc_valid <= 1'b0;
      a_dc_q     <= '0;
    end else if (a_dc_load && a_ch_en) begin
      a_cnt      <= a_cnt + 1;
      a_dc_valid <= (a_cnt == 6);
      a_dc_q     <= DW'(16'h8000) | DW'({a_cs, 8'h00}) | DW'(a_phase);
    end else begin
      a_cnt      <= 0;
      a_dc_valid <= 1'b0;
    end
  end

  // Channel model b: fixed result 0x0123.
  int b_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt      <= 0;
      b_dc_valid <= 1'b0;
      b_dc_q     <= '0;
    end else if (b_dc_load) begin
      b_cnt      <= b_cnt + 1;
      b_dc_valid <= (b_cnt == 6);
      b_dc_q     <= DW'(16'h0123);
    end else begin
      b_cnt      <= 0;
      b_dc_valid <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   exp_cs, exp_ph, nres, ndone, low_run;
  logic seen_load;
  logic [DW-1:0] held;

  initial begin
    s_data_ok = 1'b1;
    s_data    = {18{32'h1234_5678}};

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_busy", VW'(a_busy), VW'(0));
    chk("rst_m_valid", VW'(a_m_valid), VW'(0));
    chk("rst_dc_load", VW'(a_dc_load), VW'(0));
    chk("rst_s_ready", VW'(a_s_ready), VW'(0));
    chk("rst_d", a_d, VW'(0));
    chk("rst_cs", VW'(a_cs), VW'(0));
    chk("rst_phase", VW'(a_phase), VW'(0));
    chk("rst_err", VW'(a_err), VW'(0));
    chk("rst_frame_done", VW'(a_frame_done), VW'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- single slice on b ----------------
    b_start = 1'b1;
    tick();
    b_start   = 1'b0;
    b_s_valid = 1'b1;
    #1;
    chk("b_s_ready_wait", VW'(b_s_ready), VW'(1));
    tick();                                   // edge T: accepted
    b_s_valid = 1'b0;
    chk("b_load_T", VW'(b_dc_load), VW'(1));
    chk("b_d_T", b_d, s_data);
    repeat (7) tick();                        // T+7
    chk("b_no_valid_T7", VW'(b_m_valid), VW'(0));
    tick();                                   // T+8
    chk("b_m_valid_T8", VW'(b_m_valid), VW'(1));
    chk("b_m_data_T8", VW'(b_m_data), VW'(16'h0123));
    chk("b_m_cs_T8", VW'(b_m_cs), VW'(0));
    chk("b_m_phase_T8", VW'(b_m_phase), VW'(0));
    chk("b_done_T8", VW'(b_frame_done), VW'(0));
    tick();                                   // T+9
    chk("b_done_T9", VW'(b_frame_done), VW'(1));
    chk("b_busy_T9", VW'(b_busy), VW'(0));
    tick();
    chk("b_done_T10", VW'(b_frame_done), VW'(0));
    chk("b_busy_T10", VW'(b_busy), VW'(0));

    // ---------------- input starvation, then full frame on a ----------------
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("starve_dc_load", VW'(a_dc_load), VW'(0));
    end
    chk("starve_busy", VW'(a_busy), VW'(1));
    chk("starve_s_ready", VW'(a_s_ready), VW'(1));
    chk("starve_cs", VW'(a_cs), VW'(0));
    chk("starve_phase", VW'(a_phase), VW'(0));

    a_s_valid = 1'b1;
    exp_cs = 0; exp_ph = 0; nres = 0; ndone = 0; low_run = 0; seen_load = 1'b0;
    for (int cyc = 0; cyc < 3000 && ndone == 0; cyc++) begin
      tick();
      if (a_m_valid) begin
        chk("frame_m_cs", VW'(a_m_cs), VW'(exp_cs));
        chk("frame_m_phase", VW'(a_m_phase), VW'(exp_ph));
        chk("frame_m_data", VW'(a_m_data), VW'(16'h8000 | (exp_cs << 8) | exp_ph));
        nres++;
        if (exp_ph == 7) begin
          exp_ph = 0;
          exp_cs++;
        end else begin
          exp_ph++;
        end
      end
      if (a_frame_done) ndone++;
      // Loads drop for the GAP cycle and stay low through the WAIT_IN
      // cycle in which the next vector is taken: two samples low.
      if (a_dc_load) begin
        if (seen_load && low_run != 0) chk("frame_load_gap", VW'(low_run), VW'(2));
        seen_load = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
    end
    a_s_valid = 1'b0;
    chk("frame_results", VW'(nres), VW'(128));
    chk("frame_done_count", VW'(ndone), VW'(1));
    chk("frame_busy_end", VW'(a_busy), VW'(0));
    tick();
    chk("frame_done_single", VW'(a_frame_done), VW'(0));

    // ---------------- output backpressure ----------------
    a_start = 1'b1;
    tick();
    a_start   = 1'b0;
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    for (int i = 0; i < 20 && !a_m_valid; i++) tick();
    chk("bp_first_valid", VW'(a_m_valid), VW'(1));
    chk("bp_first_data", VW'(a_m_data), VW'(16'h8000));
    held = a_m_data;
    tick();                                   // GAP -> WAIT_IN
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_s_ready", VW'(a_s_ready), VW'(0));
      chk("bp_dc_load", VW'(a_dc_load), VW'(0));
      chk("bp_m_valid", VW'(a_m_valid), VW'(1));
      chk("bp_m_data", VW'(a_m_data), VW'(held));
    end
    a_m_ready = 1'b1;
    #1;
    chk("bp_s_ready_release", VW'(a_s_ready), VW'(1));
    tick();                                   // second vector accepted
    chk("bp_m_valid_clear", VW'(a_m_valid), VW'(0));
    chk("bp_second_load", VW'(a_dc_load), VW'(1));
    chk("bp_second_phase", VW'(a_phase), VW'(1));
    a_s_valid = 1'b0;
    repeat (2) tick();

    // ---------------- reset mid-RUN ----------------
    chk("mid_load_before", VW'(a_dc_load), VW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_dc_load", VW'(a_dc_load), VW'(0));
    chk("mid_ws_load", VW'(a_ws_load), VW'(0));
    chk("mid_busy", VW'(a_busy), VW'(0));
    chk("mid_phase", VW'(a_phase), VW'(0));
    chk("mid_cs", VW'(a_cs), VW'(0));
    chk("mid_d", a_d, VW'(0));
    chk("mid_m_data", VW'(a_m_data), VW'(0));
    chk("mid_s_ready", VW'(a_s_ready), VW'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_done", VW'(a_frame_done), VW'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_done", VW'(a_frame_done), VW'(0));
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("restart_busy", VW'(a_busy), VW'(1));
    chk("restart_cs", VW'(a_cs), VW'(0));
    chk("restart_phase", VW'(a_phase), VW'(0));

    // ---------------- channel never answers ----------------
    a_ch_en   = 1'b0;
    a_s_valid = 1'b1;
    tick();                                   // edge T: accepted
    a_s_valid = 1'b0;
`ifdef DOT_FEEDER_TIMEOUT_EN
    repeat (63) tick();                       // T+63
    chk("to_err_early", VW'(a_err), VW'(0));
    tick();                                   // T+64
    chk("to_err_set", VW'(a_err), VW'(1));
    chk("to_load_drop", VW'(a_dc_load), VW'(0));
    repeat (5) tick();
    chk("to_no_result", VW'(a_m_valid), VW'(0));
    chk("to_phase_adv", VW'(a_phase), VW'(1));
    chk("to_err_sticky", VW'(a_err), VW'(1));
`else
    repeat (80) tick();
    chk("hang_load", VW'(a_dc_load), VW'(1));
    chk("hang_busy", VW'(a_busy), VW'(1));
    chk("hang_err", VW'(a_err), VW'(0));
    chk("hang_no_result", VW'(a_m_valid), VW'(0));
    chk("hang_phase", VW'(a_phase), VW'(0));
`endif

    rst_n = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
